// File: rtl/sht30_i2c_responder_if.sv
// Open-drain I2C bus between a master model and the SHT30 responder.
// Each side only pulls SDA low or lets it float. The resolved line is
// high unless somebody pulls it low, which models the external pull-up.
interface sht30_i2c_responder_if;
  logic scl;        // driven by the master
  logic sda_m_low;  // master pulls SDA low
  logic sda_t_low;  // target pulls SDA low (1'b0 means SDA released)
  logic sda;        // resolved wired-AND line

  assign sda = ~(sda_m_low | sda_t_low);

  modport master (output scl, output sda_m_low, input sda);
  modport slave  (input scl, input sda, output sda_t_low);
endinterface

// File: rtl/sht30_i2c_responder.sv
// SHT30 sensor model on the target side of I2C. It accepts 16-bit commands
// and serves the 6-byte T/H measurement frame with CRC-8 (poly 0x31, init 0xFF).
// SCL/SDA are oversampled by clk, so the SCL high and low phases must each
// last at least 8 clk.
module sht30_i2c_responder #(
  parameter logic [6:0]  DEV_ADDR    = 7'h44,
  parameter logic [23:0] MEAS_CYCLES = 24'd600
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sht30_i2c_responder_if.slave bus,
  input  logic [15:0]          T_src,
  input  logic [15:0]          H_src,
  output logic [15:0]          cmd,
  output logic                 cmd_valid,
  output logic                 busy,
  output logic                 meas_done,
  output logic                 data_valid
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, TX, TX_ACK, IGNORE
  } state_t;

  state_t      state, state_next;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_d, sda_d;
  logic        scl_s, sda_s;
  logic        scl_rise, scl_fall, start_det, stop_det, read_end;
  logic [3:0]  bit_cnt;
  logic [6:0]  shreg;
  logic [7:0]  cmd_hi;
  logic [7:0]  tx_sh;
  logic [2:0]  tx_idx;
  logic        byte_sel;
  logic        addr_ack;
  logic        addr_rw;
  logic        tx_started;
  logic        sda_low;
  logic [23:0] meas_cnt;
  logic [7:0]  frame [0:5];
  logic [7:0]  next_byte;

  // CRC-8 over a 16-bit word, MSB first: poly 0x31, init 0xFF, no reflection
  function automatic logic [7:0] crc8(input logic [15:0] data);
    logic [7:0] c;
    c = 8'hFF;
    for (int i = 15; i >= 0; i--) begin
      if (c[7] ^ data[i]) begin
        c = {c[6:0], 1'b0} ^ 8'h31;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign read_end  = (start_det | stop_det) & tx_started;
  assign bus.sda_t_low = sda_low;

  // Two-flop synchronizers plus one edge-detect flop; the idle bus level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl};
      sda_sync <= {sda_sync[0], bus.sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: START/STOP override everything, otherwise step on SCL edges
  always_comb begin
    state_next = state;
    if (start_det) begin
      state_next = ADDR;
    end else if (stop_det) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     state_next = IDLE;
        ADDR: begin
          if (scl_fall && (bit_cnt == 4'd8)) begin
            state_next = addr_ack ? ADDR_ACK : IGNORE;
          end else begin
            state_next = ADDR;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            state_next = addr_rw ? TX : CMD;
          end else begin
            state_next = ADDR_ACK;
          end
        end
        CMD: begin
          if (scl_fall && (bit_cnt == 4'd8)) begin
            state_next = CMD_ACK;
          end else begin
            state_next = CMD;
          end
        end
        CMD_ACK: begin
          if (scl_fall) begin
            state_next = byte_sel ? IGNORE : CMD;
          end else begin
            state_next = CMD_ACK;
          end
        end
        TX: begin
          if (scl_fall && (bit_cnt == 4'd8)) begin
            state_next = TX_ACK;
          end else begin
            state_next = TX;
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            state_next = (!sda_s && (tx_idx < 3'd5)) ? TX : IGNORE;
          end else begin
            state_next = TX_ACK;
          end
        end
        IGNORE:   state_next = IGNORE;
        default:  state_next = IDLE;
      endcase
    end
  end

  // Frame byte that follows the one currently being sent
  always_comb begin
    next_byte = 8'h00;
    case (tx_idx)
      3'd0:    next_byte = frame[1];
      3'd1:    next_byte = frame[2];
      3'd2:    next_byte = frame[3];
      3'd3:    next_byte = frame[4];
      3'd4:    next_byte = frame[5];
      default: next_byte = 8'h00;
    endcase
  end

  // Bus datapath: bit shifting, ACK drive, command capture, TX serializer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= 4'd0;
      shreg      <= 7'h00;
      cmd_hi     <= 8'h00;
      tx_sh      <= 8'h00;
      tx_idx     <= 3'd0;
      byte_sel   <= 1'b0;
      addr_ack   <= 1'b0;
      addr_rw    <= 1'b0;
      tx_started <= 1'b0;
      sda_low    <= 1'b0;
      cmd        <= 16'h0000;
      cmd_valid  <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      if (start_det || stop_det) begin
        bit_cnt    <= 4'd0;
        sda_low    <= 1'b0;
        tx_started <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg   <= {shreg[5:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                // shreg holds addr[7:1]; sda_s is the R/W bit
                addr_rw  <= sda_s;
                addr_ack <= (shreg == DEV_ADDR) && (!sda_s || (!busy && data_valid));
              end
            end else if (scl_fall && (bit_cnt == 4'd8)) begin
              sda_low <= addr_ack;
              bit_cnt <= 4'd0;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (addr_rw) begin
                // The ACK slot ends and the first data bit starts on the same fall
                sda_low    <= ~frame[0][7];
                tx_sh      <= {frame[0][6:0], 1'b0};
                tx_idx     <= 3'd0;
                tx_started <= 1'b1;
              end else begin
                sda_low  <= 1'b0;
                byte_sel <= 1'b0;
              end
            end
          end
          CMD: begin
            if (scl_rise) begin
              shreg   <= {shreg[5:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (byte_sel) begin
                  cmd       <= {cmd_hi, shreg, sda_s};
                  cmd_valid <= 1'b1;
                end else begin
                  cmd_hi <= {shreg, sda_s};
                end
              end
            end else if (scl_fall && (bit_cnt == 4'd8)) begin
              sda_low <= 1'b1;
            end
          end
          CMD_ACK: begin
            if (scl_fall) begin
              sda_low  <= 1'b0;
              bit_cnt  <= 4'd0;
              byte_sel <= 1'b1;
            end
          end
          TX: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_low <= 1'b0;
              end else begin
                sda_low <= ~tx_sh[7];
                tx_sh   <= {tx_sh[6:0], 1'b0};
              end
            end
          end
          TX_ACK: begin
            if (scl_rise && !sda_s && (tx_idx < 3'd5)) begin
              tx_idx  <= tx_idx + 3'd1;
              tx_sh   <= next_byte;
              bit_cnt <= 4'd0;
            end
          end
          default: begin
            sda_low <= 1'b0;
          end
        endcase
      end
    end
  end

  // Measurement engine: command side effects one clk after cmd_valid, busy
  // countdown, frame load, and data_valid lifetime
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      meas_cnt   <= 24'd0;
      meas_done  <= 1'b0;
      data_valid <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        frame[i] <= 8'h00;
      end
    end else begin
      meas_done <= 1'b0;
      if (cmd_valid && (cmd == 16'h30A2)) begin
        busy       <= 1'b0;
        meas_cnt   <= 24'd0;
        data_valid <= 1'b0;
        for (int i = 0; i < 6; i++) begin
          frame[i] <= 8'h00;
        end
      end else if (cmd_valid && (cmd == 16'h2C06)) begin
        busy       <= 1'b1;
        meas_cnt   <= MEAS_CYCLES;
        data_valid <= 1'b0;
      end else if (busy) begin
        if (meas_cnt <= 24'd1) begin
          busy       <= 1'b0;
          meas_cnt   <= 24'd0;
          meas_done  <= 1'b1;
          data_valid <= 1'b1;
          frame[0]   <= T_src[15:8];
          frame[1]   <= T_src[7:0];
          frame[2]   <= crc8(T_src);
          frame[3]   <= H_src[15:8];
          frame[4]   <= H_src[7:0];
          frame[5]   <= crc8(H_src);
        end else begin
          meas_cnt <= meas_cnt - 24'd1;
        end
      end else if (read_end) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sht30_i2c_responder.sv
// Directed bench for sht30_i2c_responder: a bit-banged I2C master drives
// the bus interface and each scenario task checks its own expectations.
module tb_sht30_i2c_responder;
  localparam int Q = 4;  // quarter SCL period in clk; SCL high/low = 8 clk

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] T_src, H_src, cmd;
  logic        cmd_valid, busy, meas_done, data_valid;

  sht30_i2c_responder_if bus();

  sht30_i2c_responder dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .T_src(T_src), .H_src(H_src),
    .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .meas_done(meas_done),
    .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cv_cnt = 0, md_cnt = 0, busy_cyc = 0, tlow_cyc = 0;
  logic prev_cv = 1'b0, busy_at_cv = 1'b0, busy_after_cv = 1'b0;

  // Event monitors: pulse counts, busy length, target pull-low cycles
  always @(posedge clk) begin
    if (cmd_valid) begin
      cv_cnt     <= cv_cnt + 1;
      busy_at_cv <= busy;
    end
    if (meas_done) md_cnt <= md_cnt + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (bus.sda_t_low) tlow_cyc <= tlow_cyc + 1;
    prev_cv <= cmd_valid;
    if (prev_cv) busy_after_cv <= busy;
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    bus.sda_m_low = 1'b0; clk_wait(Q);
    bus.scl = 1'b1;       clk_wait(Q);
    bus.sda_m_low = 1'b1; clk_wait(Q);
    bus.scl = 1'b0;       clk_wait(Q);
  endtask

  task automatic i2c_stop();
    bus.sda_m_low = 1'b1; clk_wait(Q);
    bus.scl = 1'b1;       clk_wait(Q);
    bus.sda_m_low = 1'b0; clk_wait(Q);
  endtask

  task automatic write_bit(input logic b);
    bus.sda_m_low = ~b; clk_wait(Q);
    bus.scl = 1'b1;     clk_wait(2 * Q);
    bus.scl = 1'b0;     clk_wait(Q);
  endtask

  task automatic read_bit(output logic b);
    bus.sda_m_low = 1'b0; clk_wait(Q);
    bus.scl = 1'b1;       clk_wait(Q);
    b = bus.sda;          clk_wait(Q);
    bus.scl = 1'b0;       clk_wait(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    acked = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~ack);
  endtask

  task automatic write_cmd(input logic [6:0] addr, input logic [15:0] c, output logic [2:0] acks);
    i2c_start();
    write_byte({addr, 1'b0}, acks[2]);
    write_byte(c[15:8], acks[1]);
    write_byte(c[7:0], acks[0]);
    i2c_stop();
  endtask

  task automatic wait_meas(input int base);
    int i;
    for (i = 0; i < 2000; i++) begin
      if (md_cnt > base) break;
      clk_wait(1);
    end
    checks++;
    if (md_cnt <= base) begin
      failures++;
      $display("FAIL meas_done_timeout: no meas_done within 2000 clk");
    end
  endtask

  task automatic do_measure();
    logic [2:0] acks;
    int base;
    base = md_cnt;
    write_cmd(7'h44, 16'h2C06, acks);
    wait_meas(base);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clk_wait(4);
    checks++; if (bus.sda_t_low !== 1'b0) begin failures++; $display("FAIL rst_sda_in_reset: got %b expected 0", bus.sda_t_low); end
    rst_n = 1'b1;
    clk_wait(4);
    checks++; if (cmd !== 16'h0000) begin failures++; $display("FAIL rst_cmd: got %h expected 0000", cmd); end
    checks++; if ({cmd_valid, busy, meas_done, data_valid} !== 4'b0000) begin failures++; $display("FAIL rst_flags: got %b expected 0000", {cmd_valid, busy, meas_done, data_valid}); end
    checks++; if (bus.sda_t_low !== 1'b0) begin failures++; $display("FAIL rst_sda: got %b expected 0", bus.sda_t_low); end
  endtask

  task automatic test_measure();
    logic [2:0] acks;
    logic       a;
    logic [7:0] got [0:5];
    logic [7:0] exp_b [0:5];
    int cv0, bc0, md0;
    exp_b[0] = 8'hBE; exp_b[1] = 8'hEF; exp_b[2] = 8'h92;
    exp_b[3] = 8'h12; exp_b[4] = 8'h34; exp_b[5] = 8'h37;
    cv0 = cv_cnt; bc0 = busy_cyc; md0 = md_cnt;
    write_cmd(7'h44, 16'h2C06, acks);
    checks++; if (acks !== 3'b111) begin failures++; $display("FAIL meas_acks: got %b expected 111", acks); end
    checks++; if (cv_cnt - cv0 !== 1) begin failures++; $display("FAIL meas_cv_count: got %0d expected 1", cv_cnt - cv0); end
    checks++; if (cmd !== 16'h2C06) begin failures++; $display("FAIL meas_cmd: got %h expected 2c06", cmd); end
    checks++; if ({busy_at_cv, busy_after_cv} !== 2'b01) begin failures++; $display("FAIL meas_busy_start: got %b expected 01", {busy_at_cv, busy_after_cv}); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL meas_busy: got %b expected 1", busy); end
    wait_meas(md0);
    clk_wait(2);
    checks++; if (busy_cyc - bc0 !== 600) begin failures++; $display("FAIL meas_busy_len: got %0d expected 600", busy_cyc - bc0); end
    checks++; if (md_cnt - md0 !== 1) begin failures++; $display("FAIL meas_done_count: got %0d expected 1", md_cnt - md0); end
    checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL meas_dv: got %b expected 1", data_valid); end
    i2c_start();
    write_byte(8'h89, a);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL read_addr_ack: got %b expected 1", a); end
    for (int i = 0; i < 6; i++) read_byte(got[i], (i < 5));
    i2c_stop();
    for (int i = 0; i < 6; i++) begin
      checks++; if (got[i] !== exp_b[i]) begin failures++; $display("FAIL read_byte%0d: got %h expected %h", i, got[i], exp_b[i]); end
    end
    clk_wait(6);
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL read_dv_clear: got %b expected 0", data_valid); end
  endtask

  task automatic test_read_busy();
    logic [2:0] acks;
    logic       a;
    int md0, tl0;
    md0 = md_cnt;
    write_cmd(7'h44, 16'h2C06, acks);
    tl0 = tlow_cyc;
    i2c_start();
    write_byte(8'h89, a);
    i2c_stop();
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL busy_read_nack: got ack=%b expected 0", a); end
    checks++; if (tlow_cyc - tl0 !== 0) begin failures++; $display("FAIL busy_read_sda: got %0d low cycles expected 0", tlow_cyc - tl0); end
    wait_meas(md0);
  endtask

  task automatic test_wrong_addr();
    logic [2:0] acks;
    int cv0, tl0;
    cv0 = cv_cnt; tl0 = tlow_cyc;
    write_cmd(7'h45, 16'h2C06, acks);
    clk_wait(4);
    checks++; if (acks !== 3'b000) begin failures++; $display("FAIL wrong_addr_acks: got %b expected 000", acks); end
    checks++; if (cv_cnt - cv0 !== 0) begin failures++; $display("FAIL wrong_addr_cv: got %0d expected 0", cv_cnt - cv0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wrong_addr_busy: got %b expected 0", busy); end
    checks++; if (tlow_cyc - tl0 !== 0) begin failures++; $display("FAIL wrong_addr_sda: got %0d low cycles expected 0", tlow_cyc - tl0); end
  endtask

  task automatic test_soft_reset();
    logic [2:0] acks;
    logic       a;
    int cv0, md0;
    write_cmd(7'h44, 16'h2C06, acks);
    clk_wait(20);
    cv0 = cv_cnt; md0 = md_cnt;
    write_cmd(7'h44, 16'h30A2, acks);
    checks++; if (cv_cnt - cv0 !== 1) begin failures++; $display("FAIL srst_cv: got %0d expected 1", cv_cnt - cv0); end
    checks++; if (cmd !== 16'h30A2) begin failures++; $display("FAIL srst_cmd: got %h expected 30a2", cmd); end
    checks++; if ({busy_at_cv, busy_after_cv} !== 2'b10) begin failures++; $display("FAIL srst_busy_fall: got %b expected 10", {busy_at_cv, busy_after_cv}); end
    clk_wait(700);
    checks++; if (md_cnt - md0 !== 0) begin failures++; $display("FAIL srst_meas_done: got %0d expected 0", md_cnt - md0); end
    i2c_start();
    write_byte(8'h89, a);
    i2c_stop();
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL srst_read_nack: got ack=%b expected 0", a); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL srst_dv: got %b expected 0", data_valid); end
  endtask

  task automatic test_partial_read();
    logic       a, b;
    logic [7:0] d0, d1;
    int tl0;
    do_measure();
    i2c_start();
    write_byte(8'h89, a);
    read_byte(d0, 1'b1);
    read_byte(d1, 1'b0);
    tl0 = tlow_cyc;
    read_bit(b);
    checks++; if ({d0, d1} !== 16'hBEEF) begin failures++; $display("FAIL partial_bytes: got %h expected beef", {d0, d1}); end
    checks++; if ((tlow_cyc - tl0 !== 0) || (b !== 1'b1)) begin failures++; $display("FAIL partial_release: got %0d low cycles bit=%b expected 0 and 1", tlow_cyc - tl0, b); end
    i2c_stop();
    clk_wait(6);
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL partial_dv: got %b expected 0", data_valid); end
  endtask

  task automatic test_repeated_start();
    logic       a;
    logic [2:0] bits;
    do_measure();
    i2c_start();
    write_byte(8'h89, a);
    for (int i = 2; i >= 0; i--) read_bit(bits[i]);
    checks++; if (bits !== 3'b101) begin failures++; $display("FAIL rs_first_bits: got %b expected 101", bits); end
    i2c_start();
    write_byte(8'h89, a);
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL rs_read_nack: got ack=%b expected 0", a); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL rs_dv: got %b expected 0", data_valid); end
    i2c_stop();
  endtask

  task automatic test_reset_mid_tx();
    logic       a, b;
    logic [2:0] acks;
    int cv0;
    do_measure();
    i2c_start();
    write_byte(8'h89, a);
    read_bit(b);
    checks++; if (bus.sda_t_low !== 1'b1) begin failures++; $display("FAIL mid_tx_driving: got %b expected 1", bus.sda_t_low); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.sda_t_low !== 1'b0) begin failures++; $display("FAIL mid_tx_async_release: got %b expected 0", bus.sda_t_low); end
    checks++; if ({cmd, cmd_valid, busy, meas_done, data_valid} !== 20'h00000) begin failures++; $display("FAIL mid_tx_outputs: got %h expected 00000", {cmd, cmd_valid, busy, meas_done, data_valid}); end
    clk_wait(3);
    rst_n = 1'b1;
    clk_wait(5);
    cv0 = cv_cnt;
    write_cmd(7'h44, 16'h2C06, acks);
    checks++; if (acks !== 3'b111) begin failures++; $display("FAIL recover_acks: got %b expected 111", acks); end
    checks++; if ((cv_cnt - cv0 !== 1) || (cmd !== 16'h2C06)) begin failures++; $display("FAIL recover_cmd: got %0d pulses cmd=%h expected 1 and 2c06", cv_cnt - cv0, cmd); end
  endtask

  initial begin
    bus.scl = 1'b1;
    bus.sda_m_low = 1'b0;
    T_src = 16'hBEEF;
    H_src = 16'h1234;
    test_reset();
    test_measure();
    test_read_busy();
    test_wrong_addr();
    test_soft_reset();
    test_partial_read();
    test_repeated_start();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sht30_i2c_responder.md
# sht30_i2c_responder

Synthesizable I2C target that emulates the SHT30 humidity/temperature sensor at the far end of the bus from `sht30_driver`. It is used as an on-chip sensor model for closed-loop bring-up and regression. It accepts 16-bit commands and serves the 6-byte measurement frame T_msb, T_lsb, CRC, H_msb, H_lsb, CRC from host-supplied codes. The block samples SCL/SDA with the system clock; it drives no internal I2C clock.

## Interface
- `DEV_ADDR`, default 7'h44: 7-bit address the block responds to.
- `MEAS_CYCLES`, default 24'd600: clk cycles the block stays busy after a measure command.
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `i2c_scl` in 1: bus SCL from master.
- `i2c_sda` inout 1: open-drain SDA; block drives 1'b0 or 1'bz only.
- `T_src` in 16: temperature code, sampled at measurement completion.
- `H_src` in 16: humidity code, sampled at measurement completion.
- `cmd` out 16: last received command word.
- `cmd_valid` out 1: one-clk pulse when a 2-byte command completes.
- `busy` out 1: measurement in progress.
- `meas_done` out 1: one-clk pulse when the frame is loaded.
- `data_valid` out 1: frame available for reading.

## Operation
- SCL and SDA each pass through a 2-flop synchronizer, followed by a 1-flop edge detector.
- START: synced SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are recognized in any state.
- A repeated START returns the block to ADDR. A STOP returns it to IDLE and releases SDA.
- Bits are sampled on the SCL rising edge, MSB first. The block changes its SDA drive only on the SCL falling edge.
- States and transitions:
  - IDLE -> ADDR on START.
  - ADDR: after 8 bits, compare addr[7:1] with DEV_ADDR.
    - Mismatch -> IGNORE; no ACK is driven.
  - Write address (R/W=0): ACK -> CMD_H -> ACK -> CMD_L -> ACK -> IGNORE.
    - Any byte after the 2nd command byte is NACKed.
  - Read address (R/W=1):
    - If busy or !data_valid: NACK -> IGNORE.
    - Otherwise ACK -> TX.
  - TX: shift out byte[idx] for idx 0..5. Then sample the master ACK bit on SCL rise.
    - ACK with idx<5: idx+1, continue TX.
    - NACK: release SDA -> IGNORE.
    - ACK after idx 5: release SDA (master reads 0xFF).
  - IGNORE: SDA released; wait for START or STOP.
- Command completion: `cmd` and `cmd_valid` update on the SCL rising edge of the 16th command bit.
  - 0x2C06: busy=1, counter loads MEAS_CYCLES, data_valid=0.
  - 0x30A2 (soft reset): busy=0, data_valid=0, frame registers cleared to 0. Any running measurement is aborted.
  - Any other value: cmd_valid still pulses; no side effects.
- Measurement end: when the counter reaches 0, on that clk:
  - busy=0.
  - Frame = {T_src[15:8], T_src[7:0], crc(T_src), H_src[15:8], H_src[7:0], crc(H_src)}.
  - data_valid=1 and meas_done pulses.
- CRC: CRC-8, polynomial 0x31, init 0xFF, no reflection, no final XOR, computed over the MSB byte then the LSB byte. Computing it combinationally from T_src/H_src at load time is permitted.
- data_valid clears when a read transaction that transmitted at least one byte ends, by STOP or repeated START.

## Timing
- Reset values:
  - SDA released (z).
  - cmd=0, cmd_valid=0, busy=0, meas_done=0, data_valid=0.
  - Frame registers = 0, counter = 0.
  - State IDLE.
- Reset is asynchronous; SDA releases combinationally-immediately on rst_n low.
- Pin-to-detect latency: 3 clk (2 sync + 1 edge).
- SDA drive changes 1 clk after a detected SCL fall, i.e. 4 clk after the pin edge.
- SCL high and low phases must each be ≥8 clk. This is met by the 12 MHz clk against the driver's 2.5 µs steps (30 clk each).
- ACK/NACK: drive (or release) SDA from the SCL fall after bit 8 until the next SCL fall.
- busy is high for exactly MEAS_CYCLES clk, starting the clk after cmd_valid.
- A START/STOP received while busy does not affect busy or the counter.

## Test plan
- Write 0x88, 0x2C, 0x06 with T_src=0xBEEF, H_src=0x1234:
  - 3 ACKs.
  - cmd_valid with cmd=0x2C06.
  - busy high 600 clk, then meas_done.
  - Read 0x89, ACK×5, NACK: bytes BE EF 92 12 34 37; data_valid=0 after STOP.
- Read 0x89 while busy: address NACKed (SDA high at 9th SCL rise); SDA never driven low through STOP.
- Address 0x8A (7'h45) write with 0x2C06: no ACK on any byte; cmd_valid never pulses; busy stays 0.
- Send 0x30A2 while busy: cmd_valid with cmd=0x30A2; busy falls the next clk; meas_done never pulses; a following read is NACKed.
- After a valid measurement:
  - Read 2 bytes, NACK the second, STOP: bytes BE EF; SDA released after the NACK bit.
  - Repeated START with 0x89 mid-byte: address phase restarts, and the read is NACKed (data_valid cleared).
- Assert rst_n low while the block drives SDA=0 during TX: SDA is z the same cycle; all outputs reach reset values; the block recovers on the next START.
